stage_if: RTL and testbench

- Instruction-fetch stage (stage 1) of the 5-stage MIPS pipeline.
- Produces the IF/ID register contents (pc4_id, instr_id) consumed by the decode stage.
- Obeys decode's stall and redirect (pc_select, pc_b, pc_j, jr target).
- Talks to instruction memory through a req/ack handshake with one request in flight.
- Architectural single branch delay slot: the instruction after a branch/jump always executes. No flush.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/stage_if_npc.sv | 23 ++
 rtl/stage_if.sv | 158 +++++++++++++++
 tb/tb_stage_if.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stages: redirect selects, special
// opcodes, the empty-slot word and the fetch FSM state encoding.
package pipeline_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    localparam logic [5:0]  OP_QUIT  = 6'b111111;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HALT = 2'b10
    } if_state_e;

endpackage

// File: rtl/stage_if_npc.sv
// Redirect target mux: picks the branch, jr or jump target from pc_select.
module stage_if_npc
    import pipeline_pkg::*;
(
    input  logic [1:0]  pc_select,
    input  logic [31:0] pc_b,
    input  logic [31:0] pc_j,
    input  logic [31:0] pc_jr,
    output logic [31:0] target
);

    // Target selection; sequential select never uses the result.
    always_comb begin
        target = pc_b;
        case (pc_select)
            PC_BR:   target = pc_b;
            PC_JR:   target = pc_jr;
            PC_J:    target = pc_j;
            default: target = pc_b;
        endcase
    end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: fills the IF/ID register from instruction memory
// over a req/ack handshake with one request in flight, honouring decode's
// stall and delayed-branch redirects.
// Optional build macro FETCH_HALT_EN: a fetched quit opcode halts fetching.
//
// state | meaning
// IDLE  | no request in flight; requests whenever the IF/ID slot frees up
// WAIT  | request issued, waiting for ack; address held, IF/ID slot empty
// HALT  | quit fetched; no further requests until reset
module stage_if
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
)(
    input  logic        clock,
    input  logic        reset_0,
    input  logic        stall,
    input  logic [1:0]  pc_select,
    input  logic [31:0] pc_b,
    input  logic [31:0] pc_j,
    input  logic [31:0] pc_jr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4_id,
    output logic [31:0] instr_id,
    output logic        valid_id
);

    if_state_e   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        redir_pending_q, redir_pending_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;

    logic        consume;
    logic        slot_free;
    logic        req_int;
    logic        ack_take;
    logic        redirect_now;
    logic        quit_hit;
    logic [31:0] target;
    logic [31:0] fetch_pc_inc;

    stage_if_npc u_npc (
        .pc_select (pc_select),
        .pc_b      (pc_b),
        .pc_j      (pc_j),
        .pc_jr     (pc_jr),
        .target    (target)
    );

    assign fetch_pc_inc = fetch_pc_q + 32'd4;
    assign consume      = valid_q & ~stall;
    assign slot_free    = ~valid_q | consume;

`ifdef FETCH_HALT_EN
    assign quit_hit = (imem_rdata[31:26] == OP_QUIT);
`else
    assign quit_hit = 1'b0;
`endif

    // Request generation: IDLE asks only when the slot can take the result.
    always_comb begin
        req_int = 1'b0;
        case (state_q)
            IDLE:    req_int = slot_free;
            WAIT:    req_int = 1'b1;
            HALT:    req_int = 1'b0;
            default: req_int = 1'b0;
        endcase
    end

    // Acks without our own outstanding request (e.g. stale after reset) are dropped.
    assign ack_take = req_int & imem_ack;
    // Redirects only count when decode actually takes the branch this cycle;
    // in IDLE a consume always coincides with the delay-slot request.
    assign redirect_now = consume & (pc_select != PC_SEQ) & req_int;

    assign imem_req  = req_int & reset_0;
    assign imem_addr = fetch_pc_q;
    assign pc4_id    = pc4_q;
    assign instr_id  = instr_q;
    assign valid_id  = valid_q;

    // Next-state logic for the fetch FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_int) begin
                    if (!imem_ack)     state_d = WAIT;
                    else if (quit_hit) state_d = HALT;
                end
            end
            WAIT: begin
                if (imem_ack) state_d = quit_hit ? HALT : IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // IF/ID slot, fetch PC and pending-redirect updates.
    always_comb begin
        fetch_pc_d      = fetch_pc_q;
        redir_pc_d      = redir_pc_q;
        redir_pending_d = redir_pending_q;
        valid_d         = valid_q;
        instr_d         = instr_q;
        pc4_d           = pc4_q;
        if (ack_take) begin
            valid_d         = 1'b1;
            instr_d         = imem_rdata;
            pc4_d           = fetch_pc_inc;
            redir_pending_d = 1'b0;
            if (redir_pending_q)   fetch_pc_d = redir_pc_q;
            else if (redirect_now) fetch_pc_d = target;
            else                   fetch_pc_d = fetch_pc_inc;
        end else begin
            if (consume) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            // Delay slot still in flight: remember where to go once it lands.
            if (redirect_now) begin
                redir_pc_d      = target;
                redir_pending_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q         <= IDLE;
            fetch_pc_q      <= RESET_PC;
            redir_pc_q      <= 32'h0;
            redir_pending_q <= 1'b0;
            valid_q         <= 1'b0;
            instr_q         <= NOP_INSTR;
            pc4_q           <= 32'h0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            redir_pc_q      <= redir_pc_d;
            redir_pending_q <= redir_pending_d;
            valid_q         <= valid_d;
            instr_q         <= instr_d;
            pc4_q           <= pc4_d;
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed scenarios plus a randomized run, checked
// against a program-order model of the delayed-branch fetch stream.
module tb_stage_if;
    import pipeline_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_0;
    logic        stall;
    logic [1:0]  pc_select;
    logic [31:0] pc_b, pc_j, pc_jr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc4_id;
    logic [31:0] instr_id;
    logic        valid_id;

    int n_pass  = 0;
    int n_total = 0;

    // memory responder state
    int          wait_mode;
    bit          in_flight;
    int          remaining;
    bit          prev_wait;
    logic [31:0] prev_addr;
    bit          halt_on = 1'b0;
    logic [31:0] halt_addr = 32'h0;

    // program-order model: address of next instruction to be consumed
    logic [31:0] m_cur;
    logic [31:0] m_t;
    bit          m_have_t;

    // per-cycle observations
    logic        obs_req, obs_valid, did_consume, hold_ok;
    logic [31:0] obs_addr, obs_instr, obs_pc4, exp_instr, exp_pc4;

    always #5 clock = ~clock;

    stage_if #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_WORD)) dut (
        .clock      (clock),
        .reset_0    (reset_0),
        .stall      (stall),
        .pc_select  (pc_select),
        .pc_b       (pc_b),
        .pc_j       (pc_j),
        .pc_jr      (pc_jr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc4_id     (pc4_id),
        .instr_id   (instr_id),
        .valid_id   (valid_id)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_on && a == halt_addr) return 32'hFC00_0000;
        return {4'h1, a[27:0]};
    endfunction

    task automatic model_reset();
        m_cur     = RESET_PC;
        m_have_t  = 1'b0;
        m_t       = 32'h0;
        in_flight = 1'b0;
        remaining = 0;
        prev_wait = 1'b0;
        prev_addr = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_0   = 1'b0;
        imem_ack  = 1'b0;
        stall     = 1'b0;
        pc_select = PC_SEQ;
        model_reset();
        repeat (2) @(negedge clock);
        reset_0 = 1'b1;
    endtask

    // One cycle, entered and left at a falling edge: drive, sample, answer memory.
    task automatic step(input logic st, input logic [1:0] sel);
        logic [31:0] nxt;
        stall     = st;
        pc_select = sel;
        #1;
        obs_req     = imem_req;
        obs_addr    = imem_addr;
        obs_valid   = valid_id;
        obs_instr   = instr_id;
        obs_pc4     = pc4_id;
        did_consume = obs_valid && !st;
        hold_ok     = !prev_wait || (obs_req && obs_addr == prev_addr);
        if (did_consume) begin
            exp_instr = mem_word(m_cur);
            exp_pc4   = m_cur + 32'd4;
            nxt       = m_have_t ? m_t : m_cur + 32'd4;
            m_have_t  = (sel != PC_SEQ);
            case (sel)
                PC_BR:   m_t = pc_b;
                PC_JR:   m_t = pc_jr;
                PC_J:    m_t = pc_j;
                default: m_t = m_t;
            endcase
            m_cur = nxt;
        end
        if (obs_req) begin
            if (!in_flight) begin
                in_flight = 1'b1;
                remaining = (wait_mode > 3) ? int'($urandom_range(0, 3)) : wait_mode;
            end
            if (remaining == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(obs_addr);
                in_flight  = 1'b0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                remaining--;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end
        prev_wait = obs_req && !imem_ack;
        prev_addr = obs_addr;
        @(negedge clock);
    endtask

    task automatic test_reset();
        #3;
        n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (valid_id !== 1'b0) $display("FAIL rst_valid got %b want 0", valid_id); else n_pass++;
        n_total++; if (instr_id !== NOP_WORD) $display("FAIL rst_instr got %h want %h", instr_id, NOP_WORD); else n_pass++;
        n_total++; if (pc4_id !== 32'h0) $display("FAIL rst_pc4 got %h want 0", pc4_id); else n_pass++;
        do_reset();
    endtask

    task automatic test_zero_wait();
        wait_mode = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, PC_SEQ);
            n_total++;
            if (obs_req !== 1'b1 || obs_addr !== 32'(4 * i))
                $display("FAIL zw_addr%0d got req=%b addr=%h want req=1 addr=%h", i, obs_req, obs_addr, 32'(4 * i));
            else n_pass++;
            if (i > 0) begin
                n_total++;
                if (obs_valid !== 1'b1 || obs_pc4 !== 32'(4 * i) || obs_instr !== mem_word(32'(4 * (i - 1))))
                    $display("FAIL zw_slot%0d got v=%b pc4=%h ins=%h want v=1 pc4=%h ins=%h", i, obs_valid, obs_pc4,
                             obs_instr, 32'(4 * i), mem_word(32'(4 * (i - 1))));
                else n_pass++;
            end
        end
    endtask

    task automatic test_wait2();
        logic [31:0] want_addr [7] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h4, 32'h8};
        bit          want_valid[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        wait_mode = 2;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, PC_SEQ);
            n_total++;
            if (obs_valid !== want_valid[i] || (obs_req && obs_addr !== want_addr[i]) ||
                (obs_valid && obs_instr !== exp_instr))
                $display("FAIL w2_cycle%0d got v=%b req=%b addr=%h want v=%b addr=%h", i, obs_valid, obs_req,
                         obs_addr, want_valid[i], want_addr[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        wait_mode = 0;
        repeat (3) step(1'b0, PC_SEQ);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, PC_SEQ);
            n_total++;
            if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc4 !== 32'hC || obs_instr !== mem_word(32'h8))
                $display("FAIL stall%0d got req=%b v=%b pc4=%h ins=%h want req=0 v=1 pc4=0000000c ins=%h", i,
                         obs_req, obs_valid, obs_pc4, obs_instr, mem_word(32'h8));
            else n_pass++;
        end
        step(1'b0, PC_SEQ);
        n_total++;
        if (obs_req !== 1'b1 || obs_addr !== 32'hC || obs_instr !== exp_instr)
            $display("FAIL stall_resume got req=%b addr=%h want req=1 addr=0000000c", obs_req, obs_addr);
        else n_pass++;
    endtask

    task automatic test_branch();
        bit found = 1'b0;
        do_reset();
        wait_mode = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (valid_id && pc4_id == 32'h14) found = 1'b1;
            else step(1'b0, PC_SEQ);
        end
        n_total++; if (!found) $display("FAIL br_reach got timeout want pc4 00000014"); else n_pass++;
        pc_b = 32'h40;
        step(1'b0, PC_BR);
        n_total++;
        if (obs_addr !== 32'h14 || obs_req !== 1'b1)
            $display("FAIL br_dslot_req got req=%b addr=%h want req=1 addr=00000014", obs_req, obs_addr);
        else n_pass++;
        step(1'b0, PC_SEQ);
        n_total++;
        if (obs_pc4 !== 32'h18 || obs_instr !== mem_word(32'h14) || obs_addr !== 32'h40)
            $display("FAIL br_dslot got pc4=%h addr=%h want pc4=00000018 addr=00000040", obs_pc4, obs_addr);
        else n_pass++;
        step(1'b0, PC_SEQ);
        n_total++;
        if (obs_pc4 !== 32'h44 || obs_instr !== mem_word(32'h40))
            $display("FAIL br_target got pc4=%h ins=%h want pc4=00000044 ins=%h", obs_pc4, obs_instr, mem_word(32'h40));
        else n_pass++;
        step(1'b0, PC_SEQ);
        n_total++;
        if (obs_pc4 !== 32'h48) $display("FAIL br_after got pc4=%h want 00000048", obs_pc4); else n_pass++;
    endtask

    task automatic test_jr();
        bit          found = 1'b0;
        bit          seen_new = 1'b0;
        int          k = 0;
        logic [31:0] got_pc4 [2] = '{32'h0, 32'h0};
        logic [31:0] new_addr = 32'h0;
        do_reset();
        wait_mode = 3;
        for (int i = 0; i < 200 && !found; i++) begin
            if (valid_id && pc4_id == 32'h14) found = 1'b1;
            else step(1'b0, PC_SEQ);
        end
        n_total++; if (!found) $display("FAIL jr_reach got timeout want pc4 00000014"); else n_pass++;
        pc_jr = 32'h80;
        step(1'b0, PC_JR);
        n_total++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h14)
            $display("FAIL jr_dslot_req got req=%b addr=%h want req=1 addr=00000014", obs_req, obs_addr);
        else n_pass++;
        for (int i = 0; i < 100 && k < 2; i++) begin
            step(1'b0, PC_SEQ);
            if (obs_req && obs_addr != 32'h14 && !seen_new) begin
                seen_new = 1'b1;
                new_addr = obs_addr;
            end
            if (did_consume) begin
                got_pc4[k] = obs_pc4;
                k++;
            end
        end
        n_total++; if (got_pc4[0] !== 32'h18) $display("FAIL jr_dslot got pc4=%h want 00000018", got_pc4[0]); else n_pass++;
        n_total++; if (got_pc4[1] !== 32'h84) $display("FAIL jr_target got pc4=%h want 00000084", got_pc4[1]); else n_pass++;
        n_total++; if (new_addr !== 32'h80) $display("FAIL jr_fetch got addr=%h want 00000080", new_addr); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        wait_mode = 0;
        repeat (2) step(1'b0, PC_SEQ);
        wait_mode = 3;
        repeat (2) step(1'b0, PC_SEQ);
        #2;
        reset_0 = 1'b0;
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL rw_req got %b want 0", imem_req); else n_pass++;
        n_total++; if (valid_id !== 1'b0) $display("FAIL rw_valid got %b want 0", valid_id); else n_pass++;
        imem_ack = 1'b0;
        model_reset();
        @(negedge clock);
        reset_0 = 1'b1;
        step(1'b0, PC_SEQ);
        n_total++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC)
            $display("FAIL rw_first got req=%b addr=%h want req=1 addr=%h", obs_req, obs_addr, RESET_PC);
        else n_pass++;
    endtask

`ifdef FETCH_HALT_EN
    task automatic test_halt();
        do_reset();
        wait_mode = 0;
        halt_on   = 1'b1;
        halt_addr = 32'h8;
        repeat (6) step(1'b0, PC_SEQ);
        n_total++; if (obs_req !== 1'b0) $display("FAIL halt_req got %b want 0", obs_req); else n_pass++;
        n_total++; if (obs_valid !== 1'b0) $display("FAIL halt_valid got %b want 0", obs_valid); else n_pass++;
        halt_on = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic       st;
        logic [1:0] sel;
        do_reset();
        wait_mode = 4;
        for (int i = 0; i < 3000; i++) begin
            st    = ($urandom_range(0, 3) == 0);
            sel   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) sel = PC_SEQ;
            pc_b  = {4'h0, 26'($urandom), 2'b00};
            pc_j  = {4'h0, 26'($urandom), 2'b00};
            pc_jr = {4'h0, 26'($urandom), 2'b00};
            step(st, sel);
            n_total++;
            if (!hold_ok) $display("FAIL rnd_hold%0d got req=%b addr=%h want req=1 addr=%h", i, obs_req, obs_addr, prev_addr);
            else n_pass++;
            if (did_consume) begin
                n_total++;
                if (obs_instr !== exp_instr || obs_pc4 !== exp_pc4)
                    $display("FAIL rnd_slot%0d got ins=%h pc4=%h want ins=%h pc4=%h", i, obs_instr, obs_pc4,
                             exp_instr, exp_pc4);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset_0    = 1'b0;
        stall      = 1'b0;
        pc_select  = PC_SEQ;
        pc_b       = 32'h0;
        pc_j       = 32'h0;
        pc_jr      = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        wait_mode  = 0;
        model_reset();
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall();
        test_branch();
        test_jr();
        test_reset_in_wait();
`ifdef FETCH_HALT_EN
        test_halt();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
